// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode field type and encodings.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD   = 3'b000;
    localparam mode_t MODE_SHR    = 3'b001;
    localparam mode_t MODE_SHL    = 3'b010;
    localparam mode_t MODE_LOAD   = 3'b011;
    localparam mode_t MODE_ROR    = 3'b100;
    localparam mode_t MODE_ROL    = 3'b101;
    localparam mode_t MODE_CNT_UP = 3'b110;
    localparam mode_t MODE_CNT_DN = 3'b111;

endpackage

// File: rtl/univ_shift_reg_dff_cell.sv
// Single-bit rising-edge storage cell with asynchronous active-high reset
// and true/complement outputs.
module dff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic c,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qp
);

    logic q_q;

    // Capture d on each rising edge; rst forces the reset value immediately.
    always_ff @(posedge c or posedge rst) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= d;
    end

    assign q  = q_q;
    assign qp = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift / rotate / load / count up-down, built from
// WIDTH dff_cell instances. Next-state selection and the counter live here.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             c,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sir,
    input  logic             sil,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qp,
    output logic             sor,
    output logic             sol,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qp_q;
    logic [WIDTH-1:0] q_d;

    // Next-state select; en=0 or HOLD feeds the current value back so the
    // cells simply reload themselves. Serial inputs only reach q in SHR/SHL.
    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode)
                MODE_HOLD:   q_d = q_q;
                MODE_SHR:    q_d = {sir, q_q[WIDTH-1:1]};
                MODE_SHL:    q_d = {q_q[WIDTH-2:0], sil};
                MODE_LOAD:   q_d = d;
                MODE_ROR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_CNT_UP: q_d = q_q + WIDTH'(1);
                MODE_CNT_DN: q_d = q_q - WIDTH'(1);
                default:     q_d = q_q;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        dff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
            .c   (c),
            .rst (rst),
            .d   (q_d[i]),
            .q   (q_q[i]),
            .qp  (qp_q[i])
        );
    end

    assign q   = q_q;
    assign qp  = qp_q;
    assign sor = q_q[0];
    assign sol = q_q[WIDTH-1];

    // Terminal count depends only on mode and q, not on en.
    always_comb begin
        tc = 1'b0;
        if (mode == MODE_CNT_UP && (&q_q))  tc = 1'b1;
        if (mode == MODE_CNT_DN && !(|q_q)) tc = 1'b1;
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       c = 1'b0;
    logic       rst;
    logic       en;
    mode_t      mode;
    logic [7:0] d;
    logic       sir;
    logic       sil;
    logic [7:0] q;
    logic [7:0] qp;
    logic       sor;
    logic       sol;
    logic       tc;

    int total  = 0;
    int passed = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .c    (c),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .d    (d),
        .sir  (sir),
        .sil  (sil),
        .q    (q),
        .qp   (qp),
        .sor  (sor),
        .sol  (sol),
        .tc   (tc)
    );

    always #5 c = ~c;

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = MODE_LOAD; d = v;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 8'h00; sir = 1'b0; sil = 1'b0;
        #2;
        step();
        rst = 1'b0;
        load(8'h00);
        total++;
        if (q !== 8'h00) $display("FAIL pre_reset_load q=%h exp=00", q); else passed++;
        // assert between edges
        #2 rst = 1'b1;
        #1;
        total++;
        if (q !== 8'hA5) $display("FAIL async_reset_q q=%h exp=a5", q); else passed++;
        total++;
        if (qp !== 8'h5A) $display("FAIL async_reset_qp qp=%h exp=5a", qp); else passed++;
        total++;
        if (sor !== 1'b1 || sol !== 1'b1) $display("FAIL async_reset_serial sor=%b sol=%b exp=1 1", sor, sol); else passed++;
        en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
        step();
        step();
        total++;
        if (q !== 8'hA5) $display("FAIL reset_dominates_load q=%h exp=a5", q); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_load_shift();
        load(8'h81);
        total++;
        if (q !== 8'h81 || qp !== 8'h7E) $display("FAIL load q=%h qp=%h exp=81 7e", q, qp); else passed++;
        mode = MODE_SHR; sir = 1'b0; sil = 1'b0;
        step();
        total++;
        if (q !== 8'h40 || sor !== 1'b0) $display("FAIL shr q=%h sor=%b exp=40 0", q, sor); else passed++;
        mode = MODE_SHL; sil = 1'b1; sir = 1'b1;
        step();
        total++;
        if (q !== 8'h81 || sol !== 1'b1) $display("FAIL shl1 q=%h sol=%b exp=81 1", q, sol); else passed++;
        step();
        total++;
        if (q !== 8'h03) $display("FAIL shl2 q=%h exp=03", q); else passed++;
        // SHR with sir=1 enters at MSB
        mode = MODE_SHR; sir = 1'b1;
        step();
        total++;
        if (q !== 8'h81) $display("FAIL shr_sir1 q=%h exp=81", q); else passed++;
        sir = 1'b0; sil = 1'b0;
    endtask

    task automatic test_rotate();
        logic [7:0] exp_rol [8];
        exp_rol = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        load(8'h01);
        mode = MODE_ROR; sir = 1'b0;
        step();
        total++;
        if (q !== 8'h80) $display("FAIL ror q=%h exp=80", q); else passed++;
        mode = MODE_ROL; sil = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if (q !== exp_rol[k] || sol !== exp_rol[k][7])
                $display("FAIL rol_%0d q=%h sol=%b exp=%h %b", k, q, sol, exp_rol[k], exp_rol[k][7]);
            else passed++;
        end
    endtask

    task automatic test_count_wrap();
        load(8'hFE);
        mode = MODE_CNT_UP;
        #1;
        total++;
        if (tc !== 1'b0) $display("FAIL tc_up_fe tc=%b exp=0", tc); else passed++;
        step();
        total++;
        if (q !== 8'hFF || tc !== 1'b1) $display("FAIL up_ff q=%h tc=%b exp=ff 1", q, tc); else passed++;
        // tc ignores en
        en = 1'b0;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL tc_en0 tc=%b exp=1", tc); else passed++;
        en = 1'b1;
        step();
        total++;
        if (q !== 8'h00 || tc !== 1'b0) $display("FAIL up_wrap q=%h tc=%b exp=00 0", q, tc); else passed++;
        mode = MODE_CNT_DN;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL tc_dn_00 tc=%b exp=1", tc); else passed++;
        step();
        total++;
        if (q !== 8'hFF || tc !== 1'b0) $display("FAIL dn_wrap q=%h tc=%b exp=ff 0", q, tc); else passed++;
        step();
        total++;
        if (q !== 8'hFE) $display("FAIL dn_fe q=%h exp=fe", q); else passed++;
        // tc is zero in non-count modes even at all ones
        load(8'hFF);
        mode = MODE_HOLD;
        #1;
        total++;
        if (tc !== 1'b0) $display("FAIL tc_hold tc=%b exp=0", tc); else passed++;
    endtask

    task automatic test_enable_hold();
        mode_t modes [5];
        modes = '{MODE_SHR, MODE_LOAD, MODE_ROL, MODE_CNT_UP, MODE_CNT_DN};
        load(8'h3C);
        en = 1'b0; d = 8'hFF; sir = 1'b1; sil = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mode = modes[k];
            step();
            total++;
            if (q !== 8'h3C) $display("FAIL en0_mode%0d q=%h exp=3c", modes[k], q); else passed++;
        end
        en = 1'b1; mode = MODE_HOLD;
        step();
        total++;
        if (q !== 8'h3C) $display("FAIL hold_en1 q=%h exp=3c", q); else passed++;
        sir = 1'b0; sil = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        load(8'h10);
        mode = MODE_CNT_UP;
        step(); step(); step();
        total++;
        if (q !== 8'h13) $display("FAIL count_13 q=%h exp=13", q); else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (q !== 8'hA5) $display("FAIL mid_reset q=%h exp=a5", q); else passed++;
        @(negedge c);
        rst = 1'b0;
        step();
        total++;
        if (q !== 8'hA6) $display("FAIL resume q=%h exp=a6", q); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_count_wrap();
        test_enable_hold();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
